// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter and the TLX interrupt engine port.
package interrupt_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_REQ     = 3'b010,
    ST_RELEASE = 3'b100
  } arb_state_e;

  localparam logic ENG_OP_INT  = 1'b1;  // value driven on eng_int_req to raise an interrupt
  localparam logic ENG_RSP_ACK = 1'b1;  // engine ack level meaning "request accepted"

endpackage

// File: rtl/interrupt_arbiter_rr.sv
// Combinational round-robin arbiter: lowest set request above ptr wins, wrapping via a doubled vector.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  logic [NREQ-1:0]   mask_s;
  logic [2*NREQ-1:0] dbl_s;

  // Lower half holds requests strictly above ptr; upper half is the wrapped full vector.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      mask_s[i] = (i > int'(ptr_i));
    end
    dbl_s    = {req_i, req_i & mask_s};
    gnt_id_o = '0;
    for (int i = 2 * NREQ - 1; i >= 0; i--) begin
      gnt_id_o = dbl_s[i] ? IDW'(i % NREQ) : gnt_id_o;
    end
    any_o = |req_i;
    gnt_o = any_o ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id_o) : {NREQ{1'b0}};
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Shares one TLX interrupt engine among NREQ requesters: round-robin grant, grant-time
// capture of src/ctx, 4-phase req/ack with the engine and a one-cycle ack back to the winner.
module interrupt_arbiter
  import interrupt_defs::*;
#(
  parameter  int NREQ = 4,
  parameter  int CTXW = 9,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_enable,
  input  logic [NREQ-1:0]      usr_int_req,
  input  logic [NREQ*64-1:0]   usr_int_src,
  input  logic [NREQ*CTXW-1:0] usr_int_ctx,
  output logic [NREQ-1:0]      usr_int_ack,
  output logic                 eng_int_req,
  output logic [63:0]          eng_int_src,
  output logic [CTXW-1:0]      eng_int_ctx,
  input  logic                 eng_int_ack,
  output logic                 arb_busy,
  output logic [IDW-1:0]       arb_grant_id,
  output logic [31:0]          int_count
);

  logic [NREQ-1:0] elig_s;
  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_id_s;
  logic            any_s;

  arb_state_e      state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gid_q;
  logic [NREQ-1:0] gnt_oh_q;
  logic [NREQ-1:0] ack_q;
  logic [63:0]     src_q;
  logic [CTXW-1:0] ctx_q;
  logic            req_q;
  logic            busy_q;
  logic            rel_cnt_q;
  logic [31:0]     cnt_q;

  assign elig_s = usr_int_req & req_enable;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i    (elig_s),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_s),
    .gnt_id_o (gnt_id_s),
    .any_o    (any_s)
  );

  // Arbitration/handshake FSM with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      gid_q     <= '0;
      gnt_oh_q  <= '0;
      ack_q     <= '0;
      src_q     <= 64'd0;
      ctx_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      rel_cnt_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // A stale ack from the previous handshake must clear before a new request starts.
          if (any_s && (eng_int_ack != ENG_RSP_ACK)) begin
            state_q  <= ST_REQ;
            req_q    <= ENG_OP_INT;
            busy_q   <= 1'b1;
            src_q    <= usr_int_src[64*int'(gnt_id_s) +: 64];
            ctx_q    <= usr_int_ctx[CTXW*int'(gnt_id_s) +: CTXW];
            gid_q    <= gnt_id_s;
            ptr_q    <= gnt_id_s;
            gnt_oh_q <= gnt_s;
          end
        end
        ST_REQ: begin
          if (eng_int_ack == ENG_RSP_ACK) begin
            state_q   <= ST_RELEASE;
            req_q     <= 1'b0;
            ack_q     <= gnt_oh_q;
            cnt_q     <= cnt_q + 32'd1;
            rel_cnt_q <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // Two-cycle minimum gives the served requester time to drop its request.
          if (rel_cnt_q && (eng_int_ack != ENG_RSP_ACK)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rel_cnt_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign usr_int_ack  = ack_q;
  assign eng_int_req  = req_q;
  assign eng_int_src  = src_q;
  assign eng_int_ctx  = ctx_q;
  assign arb_busy     = busy_q;
  assign arb_grant_id = gid_q;
  assign int_count    = cnt_q;

endmodule
